multiplier_pipe: RTL and testbench

MULTIPLIER_PIPE -- requirements
Module: multiplier_pipe

---
 rtl/multiplier_pkg.sv | 29 ++
 rtl/multiplier_pp.sv | 28 ++
 rtl/multiplier_pipe.sv | 152 +++++++++++++++
 tb/tb_multiplier_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared subtype encodings and decode helper for the pipelined multiplier.
package multiplier_pkg;

  localparam int unsigned SUBTYPE_W = 5;

  localparam logic [SUBTYPE_W-1:0] MULW   = 5'd0;
  localparam logic [SUBTYPE_W-1:0] MULHW  = 5'd1;
  localparam logic [SUBTYPE_W-1:0] MULHWU = 5'd2;

  // Internal result selection after decode.
  typedef enum logic [1:0] {
    OpLow,
    OpHighSigned,
    OpHighUnsigned
  } mul_op_e;

  // Unknown subtypes fall back to the low-half product.
  function automatic mul_op_e decode_op(input logic [SUBTYPE_W-1:0] subtype);
    mul_op_e op;
    op = OpLow;
    case (subtype)
      MULHW:   op = OpHighSigned;
      MULHWU:  op = OpHighUnsigned;
      default: op = OpLow;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multiplier_pp.sv
// Combinational generation of the four unsigned half-width partial products.
module multiplier_pp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] pp_ll,
  output logic [DATA_W-1:0] pp_lh,
  output logic [DATA_W-1:0] pp_hl,
  output logic [DATA_W-1:0] pp_hh
);

  localparam int unsigned H = DATA_W / 2;

  logic [H-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = a[H-1:0];
  assign a_hi = a[DATA_W-1:H];
  assign b_lo = b[H-1:0];
  assign b_hi = b[DATA_W-1:H];

  // pp_lh pairs a_lo with b_hi; pp_hl pairs a_hi with b_lo.
  assign pp_ll = DATA_W'(a_lo) * DATA_W'(b_lo);
  assign pp_lh = DATA_W'(a_lo) * DATA_W'(b_hi);
  assign pp_hl = DATA_W'(a_hi) * DATA_W'(b_lo);
  assign pp_hh = DATA_W'(a_hi) * DATA_W'(b_hi);

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined MULW/MULHW/MULHWU unit with stall and flush.
// Define MULTIPLIER_TAG_EN to carry a destination tag alongside each operation.
module multiplier_pipe
  import multiplier_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipeline_multiplier_flush,
  input  logic                 pipeline_multiplier_stall,
  input  logic                 pipeline_multiplier_valid,
  input  logic [SUBTYPE_W-1:0] pipeline_multiplier_subtype,
  input  logic [DATA_W-1:0]    pipeline_multiplier_din1,
  input  logic [DATA_W-1:0]    pipeline_multiplier_din2,
  output logic                 multiplier_pipeline_valid,
  output logic [DATA_W-1:0]    multiplier_pipeline_dout,
  output logic                 multiplier_pipeline_busy
`ifdef MULTIPLIER_TAG_EN
  ,
  input  logic [TAG_W-1:0]     pipeline_multiplier_tag,
  output logic [TAG_W-1:0]     multiplier_pipeline_tag
`endif
);

  localparam int unsigned H  = DATA_W / 2;
  // Result stages after stage 1; the last one drives the outputs.
  localparam int unsigned NR = STAGES - 1;

  if (STAGES < 2 || STAGES > 4 || TAG_W < 1 || DATA_W < 8 || (DATA_W % 2) != 0) begin : gen_bad_cfg
    $error("multiplier_pipe: illegal parameter combination");
  end

  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  multiplier_pp #(
    .DATA_W (DATA_W)
  ) u_pp (
    .a     (pipeline_multiplier_din1),
    .b     (pipeline_multiplier_din2),
    .pp_ll (pp_ll),
    .pp_lh (pp_lh),
    .pp_hl (pp_hl),
    .pp_hh (pp_hh)
  );

  // Stage 1 state.
  logic                 s1_valid_q;
  logic [DATA_W-1:0]    s1_ll_q, s1_lh_q, s1_hl_q, s1_hh_q;
  logic [DATA_W-1:0]    s1_a_q, s1_b_q;
  logic [SUBTYPE_W-1:0] s1_subtype_q;

  // Result stages.
  logic                 res_valid_q [NR];
  logic [DATA_W-1:0]    res_q       [NR];

`ifdef MULTIPLIER_TAG_EN
  logic [TAG_W-1:0]     s1_tag_q;
  logic [TAG_W-1:0]     res_tag_q   [NR];
`endif

  logic                 issue;
  logic                 s1_adv;
  logic [2*DATA_W-1:0]  prod;
  logic [DATA_W-1:0]    prod_hi;
  logic [DATA_W-1:0]    corr_a, corr_b;
  logic [DATA_W-1:0]    result;
  mul_op_e              s1_op;

  assign issue  = pipeline_multiplier_valid & ~pipeline_multiplier_flush;
  assign s1_adv = s1_valid_q & ~pipeline_multiplier_flush;
  assign s1_op  = decode_op(s1_subtype_q);

  // Accumulate cross terms at bit H; the true product never exceeds 2*DATA_W bits.
  always_comb begin
    prod    = {s1_hh_q, s1_ll_q}
            + {{H{1'b0}}, s1_lh_q, {H{1'b0}}}
            + {{H{1'b0}}, s1_hl_q, {H{1'b0}}};
    prod_hi = prod[2*DATA_W-1:DATA_W];
    corr_a  = s1_b_q[DATA_W-1] ? s1_a_q : '0;
    corr_b  = s1_a_q[DATA_W-1] ? s1_b_q : '0;
    result  = prod[DATA_W-1:0];
    unique case (s1_op)
      OpHighSigned:   result = prod_hi - corr_a - corr_b;
      OpHighUnsigned: result = prod_hi;
      default:        result = prod[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_ll_q      <= '0;
      s1_lh_q      <= '0;
      s1_hl_q      <= '0;
      s1_hh_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_subtype_q <= '0;
      for (int k = 0; k < NR; k++) begin
        res_valid_q[k] <= 1'b0;
        res_q[k]       <= '0;
      end
`ifdef MULTIPLIER_TAG_EN
      s1_tag_q <= '0;
      for (int k = 0; k < NR; k++) begin
        res_tag_q[k] <= '0;
      end
`endif
    end else if (!pipeline_multiplier_stall) begin
      s1_valid_q     <= issue;
      s1_ll_q        <= pp_ll;
      s1_lh_q        <= pp_lh;
      s1_hl_q        <= pp_hl;
      s1_hh_q        <= pp_hh;
      s1_a_q         <= pipeline_multiplier_din1;
      s1_b_q         <= pipeline_multiplier_din2;
      s1_subtype_q   <= pipeline_multiplier_subtype;
      // Result data is zeroed when invalid so the output stage reads 0 when idle.
      res_valid_q[0] <= s1_adv;
      res_q[0]       <= s1_adv ? result : '0;
      for (int k = 1; k < NR; k++) begin
        res_valid_q[k] <= res_valid_q[k-1] & ~pipeline_multiplier_flush;
        res_q[k]       <= (res_valid_q[k-1] && !pipeline_multiplier_flush) ? res_q[k-1] : '0;
      end
`ifdef MULTIPLIER_TAG_EN
      s1_tag_q     <= pipeline_multiplier_tag;
      res_tag_q[0] <= s1_adv ? s1_tag_q : '0;
      for (int k = 1; k < NR; k++) begin
        res_tag_q[k] <= (res_valid_q[k-1] && !pipeline_multiplier_flush) ? res_tag_q[k-1] : '0;
      end
`endif
    end
  end

  always_comb begin
    multiplier_pipeline_busy = s1_valid_q;
    for (int k = 0; k < NR; k++) begin
      multiplier_pipeline_busy = multiplier_pipeline_busy | res_valid_q[k];
    end
  end

  assign multiplier_pipeline_valid = res_valid_q[NR-1];
  assign multiplier_pipeline_dout  = res_q[NR-1];

`ifdef MULTIPLIER_TAG_EN
  assign multiplier_pipeline_tag = res_tag_q[NR-1];
`endif

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed self-checking bench for multiplier_pipe at DATA_W=32, STAGES=2.
module tb_multiplier_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, stall, valid_in;
  logic [4:0]  subtype;
  logic [31:0] din1, din2;
  logic        valid_out, busy;
  logic [31:0] dout;
`ifdef MULTIPLIER_TAG_EN
  logic [4:0]  tag_in, tag_out;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multiplier_pipe #(
    .DATA_W (32),
    .STAGES (2),
    .TAG_W  (5)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .pipeline_multiplier_flush   (flush),
    .pipeline_multiplier_stall   (stall),
    .pipeline_multiplier_valid   (valid_in),
    .pipeline_multiplier_subtype (subtype),
    .pipeline_multiplier_din1    (din1),
    .pipeline_multiplier_din2    (din2),
    .multiplier_pipeline_valid   (valid_out),
    .multiplier_pipeline_dout    (dout),
    .multiplier_pipeline_busy    (busy)
`ifdef MULTIPLIER_TAG_EN
    ,
    .pipeline_multiplier_tag     (tag_in),
    .multiplier_pipeline_tag     (tag_out)
`endif
  );

  typedef struct {
    logic [4:0]  sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic exp_v, input logic [31:0] exp_d);
    check({name, ".valid"}, {31'd0, valid_out}, {31'd0, exp_v});
    check({name, ".dout"}, dout, exp_d);
  endtask

  task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    valid_in = 1'b1;
    subtype  = s;
    din1     = a;
    din2     = b;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{5'd0,  32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
    vecs[1]  = '{5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{5'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{5'd1,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{5'd31, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[6]  = '{5'd2,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001};
    vecs[7]  = '{5'd1,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[8]  = '{5'd2,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[9]  = '{5'd3,  32'h0001_2345, 32'h0001_0001, 32'h2346_2345};
    vecs[10] = '{5'd2,  32'h0001_2345, 32'h0001_0001, 32'h0000_0001};

    rst = 1'b1;
    idle();
    subtype = '0;
    din1    = '0;
    din2    = '0;
`ifdef MULTIPLIER_TAG_EN
    tag_in  = '0;
`endif
    tick();
    tick();
    check_out("reset", 1'b0, 32'h0);
    check("reset.busy", {31'd0, busy}, 32'd0);
`ifdef MULTIPLIER_TAG_EN
    check("reset.tag", {27'd0, tag_out}, 32'd0);
`endif
    rst = 1'b0;

    // Latency: issue in cycle N, result visible in N+2 and only there.
    issue(vecs[0].sub, vecs[0].a, vecs[0].b);
    tick();
    idle();
    check_out("lat.n1", 1'b0, 32'h0);
    check("lat.busy", {31'd0, busy}, 32'd1);
    tick();
    check_out("lat.n2", 1'b1, 32'h0000_000F);
    tick();
    check_out("lat.n3", 1'b0, 32'h0);
    check("lat.idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back table: result of vector i-1 appears after issuing vector i.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) issue(vecs[i].sub, vecs[i].a, vecs[i].b);
      else idle();
      tick();
      if (i >= 1) check_out($sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].exp);
    end
    tick();
    check_out("vec.drain", 1'b0, 32'h0);

    // Stall after the second of three issues; C is offered (and ignored) during the stall.
    issue(5'd0, 32'd2, 32'd3);           // A = 6
    tick();
    issue(5'd0, 32'd4, 32'd5);           // B = 20
    tick();
    check_out("stall.c2", 1'b1, 32'd6);
    issue(5'd0, 32'd6, 32'd7);           // C = 42
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out($sformatf("stall.hold%0d", c), 1'b1, 32'd6);
    end
    stall = 1'b0;
    tick();
    idle();
    check_out("stall.b", 1'b1, 32'd20);
    tick();
    check_out("stall.c", 1'b1, 32'd42);
    tick();
    check_out("stall.nodup", 1'b0, 32'h0);

    // Flush one cycle after issue kills the operation.
    issue(5'd0, 32'd9, 32'd9);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_out("flush.c2", 1'b0, 32'h0);
    check("flush.busy", {31'd0, busy}, 32'd0);
    tick();
    check_out("flush.c3", 1'b0, 32'h0);

    // Issue in the same cycle as flush is discarded.
    issue(5'd0, 32'd9, 32'd9);
    flush = 1'b1;
    tick();
    idle();
    check("flush_issue.busy", {31'd0, busy}, 32'd0);
    tick();
    check_out("flush_issue.out", 1'b0, 32'h0);

    // Flush under stall is ignored; result arrives one cycle late.
    issue(5'd0, 32'd7, 32'd8);
    tick();
    idle();
    flush = 1'b1;
    stall = 1'b1;
    tick();
    idle();
    check_out("flush_stall.c2", 1'b0, 32'h0);
    tick();
    check_out("flush_stall.c3", 1'b1, 32'd56);

    // Reset with two operations in flight.
    issue(5'd0, 32'd10, 32'd10);
    tick();
    issue(5'd0, 32'd11, 32'd11);
    tick();
    idle();
    check_out("rst.pre", 1'b1, 32'd100);
    rst   = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check_out("rst.post", 1'b0, 32'h0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    tick();
    check_out("rst.after1", 1'b0, 32'h0);
    tick();
    check_out("rst.after2", 1'b0, 32'h0);

`ifdef MULTIPLIER_TAG_EN
    // Tags ride with their own results.
    issue(5'd0, 32'd1, 32'd5);
    tag_in = 5'd5;
    tick();
    issue(5'd0, 32'd1, 32'd9);
    tag_in = 5'd9;
    tick();
    check_out("tag.r0", 1'b1, 32'd5);
    check("tag.t0", {27'd0, tag_out}, 32'd5);
    issue(5'd0, 32'd1, 32'd17);
    tag_in = 5'd17;
    tick();
    idle();
    tag_in = 5'd0;
    check_out("tag.r1", 1'b1, 32'd9);
    check("tag.t1", {27'd0, tag_out}, 32'd9);
    tick();
    check_out("tag.r2", 1'b1, 32'd17);
    check("tag.t2", {27'd0, tag_out}, 32'd17);
    tick();
    check("tag.idle", {27'd0, tag_out}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
